// File: rtl/b_frame_receiver.sv
// DBPSK bit-window frame receiver: differential decode, LSB-first byte assembly, frame sequencing.
// Optional reflected CRC-32 frame check is enabled by defining B_RX_CRC_CHECK_EN.
`timescale 1ns/1ps
module b_frame_receiver #(
  parameter int CLKS_PER_BIT = 50,
  parameter int SAMPLE_POINT = 25,
  parameter int FRAME_BYTES  = 38
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       s_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_last,
  output logic       frame_done,
  output logic       abort,
  output logic       crc_ok,
  output logic       busy,
  output logic [1:0] state_dbg
);

  // Output handshake: byte_valid is a single-cycle strobe with no ready/backpressure;
  // byte_data is stable from that strobe until the next one.
  localparam int WIN_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = $clog2(FRAME_BYTES + 1);
  localparam logic [WIN_W-1:0]  SP_CNT    = WIN_W'(SAMPLE_POINT);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(CLKS_PER_BIT - 1);
  localparam logic [WIN_W-1:0]  WIN_FIRST = WIN_W'((CLKS_PER_BIT > 1) ? 1 : 0);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);
  localparam logic              SAMPLE_AT_ZERO = (SAMPLE_POINT == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIN_W-1:0]  win_cnt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [7:0]        shift_reg;
  logic              ref_loaded;
  logic              prev_phase;

  logic              sample_now;
  logic              data_bit;
  logic [7:0]        assembled;
  logic [WIN_W-1:0]  win_next;
  logic              begin_frame;

  assign sample_now  = (win_cnt == SP_CNT);
  assign data_bit    = s_in ^ prev_phase;
  assign assembled   = {data_bit, shift_reg[7:1]};
  assign win_next    = (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
  // A start while receiving restarts; a start during the single DONE cycle is not honoured.
  assign begin_frame = start && enable && (state != DONE);
  assign state_dbg   = state;

`ifdef B_RX_CRC_CHECK_EN
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  logic [31:0] crc;
  logic [31:0] crc_next;
  assign crc_next = {1'b0, crc[31:1]} ^ ((crc[0] ^ data_bit) ? CRC_POLY : 32'h0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      win_cnt    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shift_reg  <= '0;
      ref_loaded <= 1'b0;
      prev_phase <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
      crc_ok     <= 1'b0;
      busy       <= 1'b0;
`ifdef B_RX_CRC_CHECK_EN
      crc        <= CRC_INIT;
`endif
    end else begin
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
      if (begin_frame) begin
        // This cycle is window cycle 0; it only samples when the sample point is 0.
        abort      <= (state == RECV);
        state      <= RECV;
        busy       <= 1'b1;
        crc_ok     <= 1'b0;
        win_cnt    <= WIN_FIRST;
        bit_cnt    <= '0;
        byte_cnt   <= '0;
        ref_loaded <= SAMPLE_AT_ZERO;
        prev_phase <= s_in;
`ifdef B_RX_CRC_CHECK_EN
        crc        <= CRC_INIT;
`endif
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RECV: begin
            if (!enable) begin
              // Carrier lost: the partial byte is dropped silently.
              abort <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              win_cnt <= win_next;
              if (sample_now) begin
                prev_phase <= s_in;
                ref_loaded <= 1'b1;
                if (ref_loaded) begin
                  shift_reg <= assembled;
                  bit_cnt   <= bit_cnt + 3'd1;
`ifdef B_RX_CRC_CHECK_EN
                  crc       <= crc_next;
`endif
                  if (bit_cnt == 3'd7) begin
                    byte_data  <= assembled;
                    byte_valid <= 1'b1;
                    byte_cnt   <= byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                      byte_last <= 1'b1;
                      state     <= DONE;
                    end
                  end
                end
              end
            end
          end
          DONE: begin
            frame_done <= 1'b1;
`ifdef B_RX_CRC_CHECK_EN
            crc_ok     <= (crc == CRC_RESIDUE);
`else
            crc_ok     <= 1'b0;
`endif
            state      <= IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_b_frame_receiver.sv
// Scoreboard bench for b_frame_receiver: DBPSK-encoded directed frames, expected bytes/events
// queued with their arrival cycle and checked by an independent monitor.
`timescale 1ns/1ps
module tb_b_frame_receiver;
  localparam int CPB   = 50;
  localparam int SP    = 25;
  localparam int FB    = 13;
  localparam int NBITS = FB * 8;
`ifdef B_RX_CRC_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset, enable, start, s_in;
  logic [7:0] byte_data;
  logic byte_valid, byte_last, frame_done, abort, crc_ok, busy;
  logic [1:0] state_dbg;
  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  b_frame_receiver #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .FRAME_BYTES(FB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .s_in(s_in),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
    .frame_done(frame_done), .abort(abort), .crc_ok(crc_ok), .busy(busy),
    .state_dbg(state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [40:0] exp_q[$];        // {last, data, cycle}
  logic [32:0] exp_done_q[$];   // {crc_ok, cycle}
  logic [31:0] exp_abort_q[$];  // cycle
  logic [7:0]  frame_buf [FB];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected pulse want none (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin : monitor
    logic [40:0] eb;
    logic [32:0] ed;
    logic [31:0] ea;
    if (byte_valid === 1'b1) begin
      if (exp_q.size() == 0) unexpected("byte_valid");
      else begin
        eb = exp_q.pop_front();
        check("byte_data", 32'(byte_data), 32'(eb[39:32]));
        check("byte_last", 32'(byte_last), 32'(eb[40]));
        check("byte_cycle", cyc, eb[31:0]);
      end
    end
    if (frame_done === 1'b1) begin
      if (exp_done_q.size() == 0) unexpected("frame_done");
      else begin
        ed = exp_done_q.pop_front();
        check("crc_ok", 32'(crc_ok), 32'(ed[32]));
        check("done_cycle", cyc, ed[31:0]);
      end
    end
    if (abort === 1'b1) begin
      if (exp_abort_q.size() == 0) unexpected("abort");
      else begin
        ea = exp_abort_q.pop_front();
        check("abort_cycle", cyc, ea);
      end
    end
  end

  // driver: kind 0 = full frame, 1 = drop enable at stop_win, 2 = leave for restart, 3 = reset
  task automatic send(input int stop_win, input int kind, input int flip, input logic exp_crc);
    logic [7:0] rx [FB];
    logic       ph [NBITS+1];
    logic       bit_v;
    int         p0;
    int         nwin;
    ph[0] = ($urandom_range(0, 1) != 0);
    for (int i = 0; i < NBITS; i++) begin
      bit_v = frame_buf[i/8][i%8];
      if (i == flip) bit_v = ~bit_v;
      rx[i/8][i%8] = bit_v;
      ph[i+1] = ph[i] ^ bit_v;
    end
    p0   = int'(cyc) + 1;
    nwin = (kind == 0) ? NBITS + 1 : stop_win;
    for (int b = 0; b < FB; b++)
      if (kind == 0 || 8*b + 8 < stop_win)
        exp_q.push_back({(kind == 0 && b == FB-1), rx[b], 32'(p0 + (8*b + 8)*CPB + SP)});
    if (kind == 0) exp_done_q.push_back({exp_crc & CRC_EN, 32'(p0 + NBITS*CPB + SP + 1)});
    for (int w = 0; w < nwin; w++) begin
      for (int k = 0; k < CPB; k++) begin
        start  = (w == 0 && k == 0);
        enable = 1'b1;
        s_in   = ph[w];
        @(negedge clk);
        if (w == 0 && k == 0) begin
          check("busy_in_recv", 32'(busy), 32'd1);
          check("crc_ok_cleared", 32'(crc_ok), 32'd0);
        end
      end
    end
    start = 1'b0;
    case (kind)
      1: begin
        exp_abort_q.push_back(cyc + 1);
        enable = 1'b0;
        @(negedge clk);
        check("busy_after_abort", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        enable = 1'b1;
      end
      2: exp_abort_q.push_back(cyc + 1);
      3: begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_byte_data", 32'(byte_data), 32'd0);
        check("rst_mid_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_abort", 32'(abort), 32'd0);
        check("rst_mid_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
      end
      default: repeat (10) @(negedge clk);
    endcase
  endtask

  task automatic load_crc_frame();
    logic [7:0] v [FB] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                           8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int i = 0; i < FB; i++) frame_buf[i] = v[i];
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; s_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_last", 32'(byte_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_crc_ok", 32'(crc_ok), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // constant phase: all-zero bytes, CRC cannot match
    for (int i = 0; i < FB; i++) frame_buf[i] = 8'h00;
    send(0, 0, -1, 1'b0);
    // check-value frame "123456789" + FCS
    load_crc_frame();
    send(0, 0, -1, 1'b1);
    // same frame with one payload bit flipped
    send(0, 0, 5, 1'b0);
    // 0xA5 leading byte
    frame_buf[0] = 8'hA5;
    send(0, 0, -1, 1'b0);
    // carrier dropped after 100 windows
    send(100, 1, -1, 1'b0);
    // second start mid-frame, then a clean full frame
    load_crc_frame();
    send(50, 2, -1, 1'b0);
    send(0, 0, -1, 1'b1);
    // reset mid-frame
    send(30, 3, -1, 1'b0);
    // start without carrier is ignored
    enable = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_no_enable_busy", 32'(busy), 32'd0);
    check("start_no_enable_state", 32'(state_dbg), 32'd0);
    repeat (CPB * 10) @(negedge clk);

    check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    check("done_outstanding", 32'(exp_done_q.size()), 32'd0);
    check("abort_outstanding", 32'(exp_abort_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
